// File: rtl/dispatch_pkg.sv
// Shared types and defaults for the child dispatch sequencer and its round-robin picker.
package dispatch_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOADED = 2'd1,
    OFFER  = 2'd2
  } dispatch_state_e;

  typedef logic [2:0] credit_t;

  localparam int      NUM_CHILDREN_DEF = 5;
  localparam int      CREDITS_DEF      = 2;
  localparam credit_t CREDIT_MAX       = 3'd7;

endpackage

// File: rtl/child_dispatch_sequencer_rr_pick.sv
// Combinational round-robin picker: first eligible child at or after ptr, cyclically.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] sel;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      sel = sum[IDX_W-1:0];
      if (!any && eligible[sel]) begin
        any   = 1'b1;
        grant = sel;
      end
    end
  end

endmodule

// File: rtl/child_dispatch_sequencer.sv
// Round-robin dispatcher feeding NUM_CHILDREN children with per-child credit tracking.
// Optional statistics counters are built when DISPATCH_STATS_EN is defined.
module child_dispatch_sequencer
  import dispatch_pkg::*;
#(
  parameter int NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter int DATA_W       = 32,
  parameter int CREDITS      = CREDITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NUM_CHILDREN-1:0] out_valid,
  input  logic [NUM_CHILDREN-1:0] out_ready,
  output logic [DATA_W-1:0]       out_data,
  input  logic [NUM_CHILDREN-1:0] done,
  output logic                    idle,
`ifdef DISPATCH_STATS_EN
  output logic [15:0]             stat_issued,
  output logic [15:0]             stat_stall,
`endif
  output logic                    err
);

  localparam int      IDX_W      = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
  localparam credit_t CREDIT_LIM = credit_t'(CREDITS);

  localparam logic [1:0] ST_EMPTY  = EMPTY;
  localparam logic [1:0] ST_LOADED = LOADED;
  localparam logic [1:0] ST_OFFER  = OFFER;

  logic [1:0]              state, state_nxt;
  logic [DATA_W-1:0]       hold;
  logic [IDX_W-1:0]        grant, rr_ptr, pick;
  logic                    any_elig;
  logic                    hs, take, err_set, credits_zero_nxt;
  logic [NUM_CHILDREN-1:0] eligible, issue_oh;
  credit_t                 credit     [NUM_CHILDREN];
  credit_t                 credit_nxt [NUM_CHILDREN];

  always_comb begin
    for (int i = 0; i < NUM_CHILDREN; i++) eligible[i] = (credit[i] < CREDIT_LIM);
  end

  rr_pick #(
    .N     (NUM_CHILDREN),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (pick),
    .any      (any_elig)
  );

  always_comb begin
    out_valid = '0;
    if (state == ST_OFFER) out_valid[grant] = 1'b1;
  end

  assign hs       = (state == ST_OFFER) && out_ready[grant];
  assign issue_oh = hs ? out_valid : '0;
  assign take     = in_valid && in_ready;
  assign out_data = hold;

  // In OFFER the slot frees on the same edge as the handshake, so ready is the child's ready.
  always_comb begin
    case (state)
      ST_EMPTY: in_ready = 1'b1;
      ST_OFFER: in_ready = out_ready[grant];
      default:  in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY:  if (take) state_nxt = ST_LOADED;
      ST_LOADED: if (any_elig) state_nxt = ST_OFFER;
      ST_OFFER:  if (hs) state_nxt = take ? ST_LOADED : ST_EMPTY;
      default:   state_nxt = ST_EMPTY;
    endcase
  end

  // An issue and a completion to the same child in one cycle cancel out.
  always_comb begin
    err_set          = 1'b0;
    credits_zero_nxt = 1'b1;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      credit_nxt[i] = credit[i];
      if (issue_oh[i] && !done[i] && credit[i] != CREDIT_MAX)
        credit_nxt[i] = credit[i] + credit_t'(1);
      else if (done[i] && !issue_oh[i] && credit[i] != '0)
        credit_nxt[i] = credit[i] - credit_t'(1);
      if (done[i] && credit[i] == '0) err_set = 1'b1;
      if (credit_nxt[i] != '0) credits_zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      hold   <= '0;
      grant  <= '0;
      rr_ptr <= '0;
      err    <= 1'b0;
      idle   <= 1'b1;
      // NOTE: the credit array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < NUM_CHILDREN; i++) credit[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      if (take) hold <= in_data;
      if (state == ST_LOADED && any_elig) grant <= pick;
      if (hs) rr_ptr <= (grant == IDX_W'(NUM_CHILDREN - 1)) ? '0 : grant + 1'b1;
      err  <= err | err_set;
      idle <= (state_nxt == ST_EMPTY) && credits_zero_nxt;
      for (int i = 0; i < NUM_CHILDREN; i++) credit[i] <= credit_nxt[i];
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      stat_issued <= stat_issued + {15'd0, hs};
      if (state == ST_LOADED && !any_elig && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_child_dispatch_sequencer.sv
// Directed testbench for child_dispatch_sequencer: a vector table plus hand-written corner sequences.
module tb_child_dispatch_sequencer;
  import dispatch_pkg::*;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int CR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '1;
  logic [DW-1:0] out_data;
  logic [N-1:0]  done = '0;
  logic          idle;
  logic          err;
`ifdef DISPATCH_STATS_EN
  logic [15:0]   stat_issued;
  logic [15:0]   stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  child_dispatch_sequencer #(
    .NUM_CHILDREN (N),
    .DATA_W       (DW),
    .CREDITS      (CR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .idle      (idle),
`ifdef DISPATCH_STATS_EN
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
`endif
    .err       (err)
  );

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] data;
    logic          exp_in_ready;
    logic [N-1:0]  exp_out_valid;
    logic          chk_data;
    logic [DW-1:0] exp_out_data;
    logic          exp_idle;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic eir,
                              input logic [N-1:0] eov, input logic chk,
                              input logic [DW-1:0] ed, input logic eidle);
    vec_t v;
    v.in_valid      = iv;
    v.data          = d;
    v.exp_in_ready  = eir;
    v.exp_out_valid = eov;
    v.chk_data      = chk;
    v.exp_out_data  = ed;
    v.exp_idle      = eidle;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    done      = '0;
    out_ready = '1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_offer(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("offer_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Push one item from EMPTY, expect it offered to exp_child, complete the handshake with done=dm.
  task automatic issue(input logic [DW-1:0] d, input int exp_child, input logic [N-1:0] dm,
                       input string tag);
    bit ok;
    out_ready = '1;
    in_valid  = 1'b1;
    in_data   = d;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
    wait_offer(ok);
    if (ok) begin
      check({tag, "_out_valid"}, 64'(out_valid), 64'(onehot(exp_child)));
      check({tag, "_out_data"}, 64'(out_data), 64'(d));
      done = dm;
      step();
      done = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;

    // Five back-to-back items, 1 item per 2 cycles, grants 0..4 in order.
    vecs[0]  = mk(1'b1, 32'hA000_0000, 1'b1, 5'b00000, 1'b0, '0,            1'b1);
    vecs[1]  = mk(1'b1, 32'hA000_0001, 1'b0, 5'b00000, 1'b0, '0,            1'b0);
    vecs[2]  = mk(1'b1, 32'hA000_0001, 1'b1, 5'b00001, 1'b1, 32'hA000_0000, 1'b0);
    vecs[3]  = mk(1'b1, 32'hA000_0002, 1'b0, 5'b00000, 1'b0, '0,            1'b0);
    vecs[4]  = mk(1'b1, 32'hA000_0002, 1'b1, 5'b00010, 1'b1, 32'hA000_0001, 1'b0);
    vecs[5]  = mk(1'b1, 32'hA000_0003, 1'b0, 5'b00000, 1'b0, '0,            1'b0);
    vecs[6]  = mk(1'b1, 32'hA000_0003, 1'b1, 5'b00100, 1'b1, 32'hA000_0002, 1'b0);
    vecs[7]  = mk(1'b1, 32'hA000_0004, 1'b0, 5'b00000, 1'b0, '0,            1'b0);
    vecs[8]  = mk(1'b1, 32'hA000_0004, 1'b1, 5'b01000, 1'b1, 32'hA000_0003, 1'b0);
    vecs[9]  = mk(1'b0, '0,            1'b0, 5'b00000, 1'b0, '0,            1'b0);
    vecs[10] = mk(1'b0, '0,            1'b1, 5'b10000, 1'b1, 32'hA000_0004, 1'b0);
    vecs[11] = mk(1'b0, '0,            1'b1, 5'b00000, 1'b0, '0,            1'b0);

    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_err", 64'(err), 64'd0);

    for (int i = 0; i < 12; i++) begin
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].data;
      out_ready = '1;
      done      = '0;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_out_data));
      check($sformatf("vec%0d_idle", i), 64'(idle), 64'(vecs[i].exp_idle));
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("t1_credit%0d", i), 64'(dut.credit[i]), 64'd1);
    check("t1_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    // Fill every child to its credit limit, then watch the eleventh item stall until done[3].
    do_reset();
    for (int i = 0; i < 10; i++) issue(32'hB000_0000 + DW'(i), i % N, '0, $sformatf("t2_item%0d", i));
    for (int i = 0; i < N; i++) check($sformatf("t2_credit%0d", i), 64'(dut.credit[i]), 64'd2);
    in_valid = 1'b1;
    in_data  = 32'hB000_000A;
    #1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_stall%0d_in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("t2_stall%0d_out_valid", i), 64'(out_valid), 64'd0);
      step();
    end
    done = 5'b01000;
    step();
    done = '0;
    wait_offer(ok);
    if (ok) begin
      check("t2_item10_out_valid", 64'(out_valid), 64'(onehot(3)));
      check("t2_item10_out_data", 64'(out_data), 64'hB000_000A);
      step();
    end
`ifdef DISPATCH_STATS_EN
    check("t2_stat_issued", 64'(stat_issued), 64'd11);
    check("t2_stat_stall", 64'(stat_stall), 64'd4);
`endif

    // Child 0 holds off its ready for four cycles while every other child is ready.
    do_reset();
    out_ready = 5'b11110;
    in_valid  = 1'b1;
    in_data   = 32'hC0DE_0001;
    #1;
    step();
    in_valid = 1'b0;
    wait_offer(ok);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_hold%0d_out_valid", i), 64'(out_valid), 64'(onehot(0)));
      check($sformatf("t3_hold%0d_out_data", i), 64'(out_data), 64'hC0DE_0001);
      check($sformatf("t3_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
      step();
    end
    out_ready = '1;
    #1;
    check("t3_release_in_ready", 64'(in_ready), 64'd1);
    step();
    check("t3_credit0", 64'(dut.credit[0]), 64'd1);
    check("t3_busy_idle", 64'(idle), 64'd0);
    done = 5'b00001;
    step();
    done = '0;
    check("t3_done_idle", 64'(idle), 64'd1);
    check("t3_done_credit0", 64'(dut.credit[0]), 64'd0);

    // Same-cycle issue and completion on child 1; then an unmatched done on child 2.
    do_reset();
    for (int i = 0; i < 6; i++) issue(32'hD000_0000 + DW'(i), i % N, '0, $sformatf("t4_item%0d", i));
    issue(32'hD000_0006, 1, 5'b00010, "t4_same");
    check("t4_credit1", 64'(dut.credit[1]), 64'd1);
    check("t4_credit0", 64'(dut.credit[0]), 64'd2);
    done = 5'b00100;
    step();
    check("t4_first_done_err", 64'(err), 64'd0);
    check("t4_first_done_credit2", 64'(dut.credit[2]), 64'd0);
    step();
    done = '0;
    check("t4_extra_done_err", 64'(err), 64'd1);
    check("t4_extra_done_credit2", 64'(dut.credit[2]), 64'd0);
    repeat (3) step();
    check("t4_err_sticky", 64'(err), 64'd1);

    // Reset asserted mid-OFFER: offer drops at once, state and credits clear.
    out_ready = '0;
    in_valid  = 1'b1;
    in_data   = 32'hE000_0001;
    #1;
    step();
    in_valid = 1'b0;
    wait_offer(ok);
    check("t5_pre_out_valid", 64'(out_valid), 64'(onehot(2)));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_out_valid", 64'(out_valid), 64'd0);
    check("t5_async_in_ready", 64'(in_ready), 64'd1);
    out_ready = '1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    check("t5_idle", 64'(idle), 64'd1);
    check("t5_err", 64'(err), 64'd0);
    check("t5_out_data", 64'(out_data), 64'd0);
    for (int i = 0; i < N; i++) check($sformatf("t5_credit%0d", i), 64'(dut.credit[i]), 64'd0);
    issue(32'hE000_0002, 0, '0, "t5_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
